// File: rtl/fullconn_wupdate_l1.sv
// Layer-1 weight store: correlates delta/x bitstreams over a window, commits saturated sign/magnitude
// weights and regenerates alpha/SIGN_alpha bitstreams. Optional direct weight load: FULLCONN_WLOAD_EN.
module fullconn_wupdate_l1 #(
    parameter int N_H   = 8,
    parameter int N_X   = 5,
    parameter int WBITS = 8,
    parameter int LBITS = 10,
    parameter int WIN   = 512,
    parameter int SHIFT = 4
) (
    input  logic                        CLK,
    input  logic                        INIT,
    input  logic [N_X-1:0]              x,
    input  logic [N_H-1:0]              delta,
    input  logic [N_H-1:0]              SIGN_delta,
    input  logic                        start,
`ifdef FULLCONN_WLOAD_EN
    input  logic                        wload,
    input  logic [$clog2(N_H*N_X)-1:0]  waddr,
    input  logic [WBITS:0]              wdata,
`endif
    output logic                        busy,
    output logic                        done,
    output logic [N_H*N_X-1:0]          alpha,
    output logic [N_H*N_X-1:0]          SIGN_alpha
);

    localparam int NW     = N_H * N_X;
    localparam int ADDR_W = $clog2(N_H * N_X);
    localparam int SW     = ((LBITS > WBITS) ? LBITS : WBITS) + 2;

    localparam logic [15:0]             LFSR_SEED = 16'hACE1;
    localparam logic [LBITS-1:0]        CNT_LAST  = LBITS'(WIN - 32'sd1);
    localparam logic [LBITS-1:0]        CNT_ZERO  = {LBITS{1'b0}};
    localparam logic [LBITS-1:0]        CNT_ONE   = {{(LBITS-1){1'b0}}, 1'b1};
    localparam logic signed [LBITS:0]   ACC_ZERO  = {(LBITS+1){1'b0}};
    localparam logic signed [LBITS:0]   ACC_P1    = {{LBITS{1'b0}}, 1'b1};
    localparam logic signed [LBITS:0]   ACC_M1    = {(LBITS+1){1'b1}};
    localparam logic signed [SW-1:0]    W_MAX     = $signed({{(SW-WBITS){1'b0}}, {WBITS{1'b1}}});
    localparam logic signed [SW-1:0]    SW_ZERO   = {SW{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t                     state_r;
    state_t                     state_s;
    logic [LBITS-1:0]           cnt_r;
    logic [15:0]                lfsr_r;
    logic                       busy_r;
    logic                       done_r;
    logic [NW-1:0]              alpha_r;
    logic [NW-1:0]              sign_alpha_r;
    logic [NW-1:0]              w_sign_r;
    logic [WBITS-1:0]           w_mag_r [NW];
    logic signed [LBITS:0]      acc_r   [NW];
    logic [WBITS-1:0]           rnd_s   [NW];

    // Random threshold: low WBITS bits of the LFSR rotated left by rot.
    function automatic logic [WBITS-1:0] rnd_slice(input logic [15:0] l, input int rot);
        logic [WBITS-1:0] r;
        for (int j = 0; j < WBITS; j++) begin
            r[j] = l[4'((j - rot + 16) % 16)];
        end
        return r;
    endfunction

    // New weight = saturate(w + (acc >>> SHIFT)), returned as {sign, magnitude} with -0 folded to +0.
    function automatic logic [WBITS:0] commit_w(input logic s, input logic [WBITS-1:0] m,
                                                input logic signed [LBITS:0] a);
        logic signed [SW-1:0] wv;
        logic signed [SW-1:0] av;
        logic signed [SW-1:0] sum;
        logic [WBITS:0]       res;
        wv  = $signed({{(SW-WBITS){1'b0}}, m});
        wv  = s ? -wv : wv;
        av  = $signed({{(SW-LBITS-1){a[LBITS]}}, a});
        av  = av >>> SHIFT;
        sum = wv + av;
        if (sum > W_MAX) begin
            res = {1'b0, {WBITS{1'b1}}};
        end else if (sum < -W_MAX) begin
            res = {1'b1, {WBITS{1'b1}}};
        end else if (sum < SW_ZERO) begin
            res = {1'b1, WBITS'(-sum)};
        end else begin
            res = {1'b0, WBITS'(sum)};
        end
        return res;
    endfunction

    // Window sequencing: IDLE -> ACCUM for WIN cycles -> one COMMIT cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_s = S_ACCUM;
                else       state_s = S_IDLE;
            end
            S_ACCUM: begin
                if (cnt_r == CNT_LAST) state_s = S_COMMIT;
                else                   state_s = S_ACCUM;
            end
            S_COMMIT: state_s = S_IDLE;
            default:  state_s = S_IDLE;
        endcase
    end

    // State, window counter and registered handshake outputs.
    always_ff @(posedge CLK or negedge INIT) begin
        if (!INIT) begin
            state_r <= S_IDLE;
            cnt_r   <= CNT_ZERO;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != S_IDLE);
            done_r  <= (state_r == S_COMMIT);
            if (state_r == S_ACCUM) cnt_r <= cnt_r + CNT_ONE;
            else                    cnt_r <= CNT_ZERO;
        end
    end

    // Free-running Fibonacci LFSR, taps 16,14,13,11.
    always_ff @(posedge CLK or negedge INIT) begin
        if (!INIT) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= {lfsr_r[0] ^ lfsr_r[2] ^ lfsr_r[3] ^ lfsr_r[5], lfsr_r[15:1]};
        end
    end

    // Per-weight threshold slices of the LFSR.
    always_comb begin
        for (int i = 0; i < NW; i++) begin
            rnd_s[i] = rnd_slice(lfsr_r, (3 * i) % 16);
        end
    end

    // Accumulate correlations in ACCUM, commit in COMMIT, optional direct load in IDLE.
    always_ff @(posedge CLK or negedge INIT) begin
        if (!INIT) begin
            for (int i = 0; i < NW; i++) begin
                w_sign_r[i] <= 1'b0;
                w_mag_r[i]  <= {WBITS{1'b0}};
                acc_r[i]    <= ACC_ZERO;
            end
        end else begin
            for (int h = 0; h < N_H; h++) begin
                for (int k = 0; k < N_X; k++) begin
                    if (state_r == S_ACCUM) begin
                        // Descent: a negative delta pushes the weight up.
                        if (delta[h] && x[k]) begin
                            acc_r[h*N_X+k] <= acc_r[h*N_X+k] + (SIGN_delta[h] ? ACC_P1 : ACC_M1);
                        end
                    end else if (state_r == S_COMMIT) begin
                        {w_sign_r[h*N_X+k], w_mag_r[h*N_X+k]} <=
                            commit_w(w_sign_r[h*N_X+k], w_mag_r[h*N_X+k], acc_r[h*N_X+k]);
                        acc_r[h*N_X+k] <= ACC_ZERO;
                    end
`ifdef FULLCONN_WLOAD_EN
                    else if (wload && (waddr == ADDR_W'(h*N_X+k))) begin
                        w_sign_r[h*N_X+k] <= wdata[WBITS] & (|wdata[WBITS-1:0]);
                        w_mag_r[h*N_X+k]  <= wdata[WBITS-1:0];
                    end
`endif
                end
            end
        end
    end

    // Registered bitstreams: alpha fires when magnitude beats the random threshold.
    always_ff @(posedge CLK or negedge INIT) begin
        if (!INIT) begin
            alpha_r      <= {NW{1'b0}};
            sign_alpha_r <= {NW{1'b0}};
        end else begin
            for (int i = 0; i < NW; i++) begin
                alpha_r[i] <= (w_mag_r[i] > rnd_s[i]);
            end
            sign_alpha_r <= w_sign_r;
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign alpha      = alpha_r;
    assign SIGN_alpha = sign_alpha_r;

endmodule
